// File: rtl/missile_bank_if.sv
// missile_bank bus: ship/alien inputs, missile/alien-state outputs.
// Parameters must match the missile_bank instance they connect to.
interface missile_bank_if #(
    parameter int NUM_MISSILES = 3,
    parameter int NUM_ALIENS   = 12
);
    logic [7:0]                 keycode;
    logic [9:0]                 ShipX;
    logic [10*NUM_ALIENS-1:0]   AlienX;
    logic [10*NUM_ALIENS-1:0]   AlienY;
    logic                       clear_hits;
    logic [10*NUM_MISSILES-1:0] MissileX;
    logic [10*NUM_MISSILES-1:0] MissileY;
    logic [NUM_MISSILES-1:0]    missile_active;
    logic [NUM_ALIENS-1:0]      alien_hit;
    logic [NUM_ALIENS-1:0]      hit_pulse;
    logic                       all_dead;

    modport master (
        output keycode, ShipX, AlienX, AlienY, clear_hits,
        input  MissileX, MissileY, missile_active,
        input  alien_hit, hit_pulse, all_dead
    );

    modport slave (
        input  keycode, ShipX, AlienX, AlienY, clear_hits,
        output MissileX, MissileY, missile_active,
        output alien_hit, hit_pulse, all_dead
    );
endinterface

// File: rtl/missile_bank.sv
// Player missile engine: launch, flight, alien collision, hit state.
// All state advances once per frame_clk (vertical sync tick).
module missile_bank #(
    parameter int         NUM_MISSILES = 3,
    parameter int         NUM_ALIENS   = 12,
    parameter int         MISSILE_W    = 3,
    parameter int         MISSILE_H    = 6,
    parameter int         ALIEN_SIZE   = 25,
    parameter int         SPEED        = 4,
    parameter int         Y_START      = 434,
    parameter int         Y_TOP        = 6,
    parameter int         X_OFFSET     = 17,
    parameter int         COOLDOWN     = 8,
    parameter logic [7:0] FIRE_KEY     = 8'h2c
) (
    input logic           frame_clk,
    input logic           Reset,
    missile_bank_if.slave bus
);

    localparam logic [9:0]  X_START_RESET = 10'd337;
    localparam logic [9:0]  YS = 10'(Y_START);
    localparam logic [9:0]  YT = 10'(Y_TOP);
    localparam logic [9:0]  SP = 10'(SPEED);
    localparam logic [9:0]  XO = 10'(X_OFFSET);
    localparam logic [10:0] MW = 11'(MISSILE_W);
    localparam logic [10:0] MH = 11'(MISSILE_H);
    localparam logic [10:0] AS = 11'(ALIEN_SIZE);
    localparam int          CW = $clog2(COOLDOWN + 2);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);

    logic [9:0]              mx_q [NUM_MISSILES];
    logic [9:0]              my_q [NUM_MISSILES];
    logic [9:0]              mx_d [NUM_MISSILES];
    logic [9:0]              my_d [NUM_MISSILES];
    logic [NUM_MISSILES-1:0] act_q, act_d;
    logic [NUM_ALIENS-1:0]   hit_q, hit_d;
    logic [NUM_ALIENS-1:0]   pulse_q, pulse_d;
    logic [CW-1:0]           cd_q, cd_d;
    logic                    fire_prev_q;

    logic                    fire_now;
    logic                    launch_req;
    logic                    do_launch;
    logic                    taken;
    logic                    hit_one;
    logic [NUM_ALIENS-1:0]   claimed;
    logic [9:0]              park_x;
    logic [10:0]             ax, ay, mx11, my11;

    // Per-frame next state: launch, retire, collide (lowest slot and
    // lowest alien first), or move up.
    always_comb begin
        fire_now   = (bus.keycode == FIRE_KEY);
        launch_req = fire_now & ~fire_prev_q;
        park_x     = bus.ShipX + XO;
        do_launch  = launch_req && (cd_q == '0) && !(&act_q);
        taken      = 1'b0;
        hit_one    = 1'b0;
        claimed    = '0;
        ax         = '0;
        ay         = '0;
        mx11       = '0;
        my11       = '0;
        act_d      = act_q;

        if (do_launch) begin
            cd_d = CD_LOAD;
        end else if (cd_q != '0) begin
            cd_d = cd_q - CW'(1);
        end else begin
            cd_d = cd_q;
        end

        for (int i = 0; i < NUM_MISSILES; i++) begin
            mx_d[i] = mx_q[i];
            my_d[i] = my_q[i];
            if (!act_q[i]) begin
                mx_d[i]  = park_x;
                my_d[i]  = YS;
                act_d[i] = 1'b0;
                if (do_launch && !taken) begin
                    act_d[i] = 1'b1;
                    taken    = 1'b1;
                end
            end else if (my_q[i] <= YT || my_q[i] < SP) begin
                mx_d[i]  = park_x;
                my_d[i]  = YS;
                act_d[i] = 1'b0;
            end else begin
                hit_one = 1'b0;
                mx11    = {1'b0, mx_q[i]};
                my11    = {1'b0, my_q[i]};
                if (!bus.clear_hits) begin
                    for (int j = 0; j < NUM_ALIENS; j++) begin
                        ax = {1'b0, bus.AlienX[10*j +: 10]};
                        ay = {1'b0, bus.AlienY[10*j +: 10]};
                        if (!hit_one && !hit_q[j] && !claimed[j] &&
                            (mx11 + MW > ax) && (mx11 < ax + AS) &&
                            (my11 + MH > ay) && (my11 < ay + AS)) begin
                            claimed[j] = 1'b1;
                            hit_one    = 1'b1;
                        end
                    end
                end
                if (hit_one) begin
                    mx_d[i]  = park_x;
                    my_d[i]  = YS;
                    act_d[i] = 1'b0;
                end else begin
                    my_d[i] = my_q[i] - SP;
                end
            end
        end

        if (bus.clear_hits) begin
            hit_d   = '0;
            pulse_d = '0;
        end else begin
            hit_d   = hit_q | claimed;
            pulse_d = claimed;
        end
    end

    // Frame state register; reset parks every slot with no pulses.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                mx_q[i] <= X_START_RESET;
                my_q[i] <= YS;
            end
            act_q       <= '0;
            hit_q       <= '0;
            pulse_q     <= '0;
            cd_q        <= '0;
            fire_prev_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_MISSILES; i++) begin
                mx_q[i] <= mx_d[i];
                my_q[i] <= my_d[i];
            end
            act_q       <= act_d;
            hit_q       <= hit_d;
            pulse_q     <= pulse_d;
            cd_q        <= cd_d;
            fire_prev_q <= fire_now;
        end
    end

    for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_out
        assign bus.MissileX[10*g +: 10] = mx_q[g];
        assign bus.MissileY[10*g +: 10] = my_q[g];
    end

    assign bus.missile_active = act_q;
    assign bus.alien_hit      = hit_q;
    assign bus.hit_pulse      = pulse_q;
    assign bus.all_dead       = &hit_q;

endmodule

// File: tb/tb_missile_bank.sv
// Directed bench for missile_bank: launch, cooldown, hits, clear.
// Second instance uses COOLDOWN=1 to set up same-alien contention.
module tb_missile_bank;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b1;
    int   n_tests   = 0;
    int   n_fail    = 0;

    always #5 frame_clk = ~frame_clk;

    missile_bank_if #(.NUM_MISSILES(3), .NUM_ALIENS(12)) bus ();
    missile_bank_if #(.NUM_MISSILES(3), .NUM_ALIENS(12)) bus2 ();

    missile_bank #(.NUM_MISSILES(3), .NUM_ALIENS(12)) u_dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(bus)
    );

    missile_bank #(.NUM_MISSILES(3), .NUM_ALIENS(12), .COOLDOWN(1)) u_dut2 (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .bus(bus2)
    );

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic set_alien(input int j, input logic [9:0] x, input logic [9:0] y);
        bus.AlienX[10*j +: 10] = x;
        bus.AlienY[10*j +: 10] = y;
    endtask

    task automatic set_alien2(input int j, input logic [9:0] x, input logic [9:0] y);
        bus2.AlienX[10*j +: 10] = x;
        bus2.AlienY[10*j +: 10] = y;
    endtask

    task automatic do_reset();
        Reset           = 1'b1;
        bus.keycode     = 8'h00;
        bus.ShipX       = 10'd320;
        bus.clear_hits  = 1'b0;
        bus2.keycode    = 8'h00;
        bus2.ShipX      = 10'd320;
        bus2.clear_hits = 1'b0;
        for (int j = 0; j < 12; j++) begin
            set_alien(j, 10'd700, 10'd0);
            set_alien2(j, 10'd700, 10'd0);
        end
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        do_reset();
        Reset = 1'b1;
        #1;
        n_tests++;
        if (bus.missile_active !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_active got=%b exp=000", bus.missile_active);
        end
        n_tests++;
        if (bus.MissileY !== {10'd434, 10'd434, 10'd434}) begin
            n_fail++;
            $display("FAIL reset_y got=%h", bus.MissileY);
        end
        n_tests++;
        if (bus.MissileX !== {10'd337, 10'd337, 10'd337}) begin
            n_fail++;
            $display("FAIL reset_x got=%h", bus.MissileX);
        end
        n_tests++;
        if (bus.alien_hit !== 12'h000 || bus.hit_pulse !== 12'h000 ||
            bus.all_dead !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hits hit=%h pulse=%h dead=%b",
                     bus.alien_hit, bus.hit_pulse, bus.all_dead);
        end
        Reset = 1'b0;
    endtask

    task automatic test_launch();
        int  k;
        logic seen6;
        do_reset();
        bus.keycode = 8'h2c;
        step();
        bus.keycode = 8'h00;
        chk("launch_active", int'(bus.missile_active), 1);
        chk("launch_x", int'(bus.MissileX[9:0]), 337);
        chk("launch_y", int'(bus.MissileY[9:0]), 434);
        chk("idle1_y", int'(bus.MissileY[19:10]), 434);
        step();
        chk("move1_y", int'(bus.MissileY[9:0]), 430);
        step();
        chk("move2_y", int'(bus.MissileY[9:0]), 426);
        k = 2;
        seen6 = 1'b0;
        while (bus.missile_active[0] && k < 200) begin
            step();
            k++;
            if (bus.MissileY[9:0] == 10'd6 && bus.missile_active[0])
                seen6 = 1'b1;
        end
        chk("retire_frame", k, 108);
        chk("retire_seen_y6", int'(seen6), 1);
        chk("retire_park_y", int'(bus.MissileY[9:0]), 434);
        bus.ShipX = 10'd100;
        step();
        chk("idle_track_x0", int'(bus.MissileX[9:0]), 117);
        chk("idle_track_x2", int'(bus.MissileX[29:20]), 117);
        bus.ShipX = 10'd1020;
        step();
        chk("idle_wrap_x", int'(bus.MissileX[9:0]), 13);
    endtask

    task automatic test_hold();
        do_reset();
        bus.keycode = 8'h2c;
        for (int f = 0; f < 20; f++) step();
        bus.keycode = 8'h00;
        chk("hold_one_launch", int'(bus.missile_active), 1);
        bus.ShipX = 10'd200;
        step();
        chk("flight_x_fixed", int'(bus.MissileX[9:0]), 337);
        chk("idle_x_follow", int'(bus.MissileX[19:10]), 217);
    endtask

    task automatic test_cooldown();
        do_reset();
        for (int f = 0; f < 10; f++) begin
            bus.keycode = (f == 0 || f == 3 || f == 9) ? 8'h2c : 8'h00;
            step();
            if (f == 3)
                chk("cd_drop_f3", int'(bus.missile_active), 1);
            if (f == 9) begin
                chk("cd_launch_f9", int'(bus.missile_active), 3);
                chk("cd_slot1_y", int'(bus.MissileY[19:10]), 434);
                chk("cd_slot0_y", int'(bus.MissileY[9:0]), 398);
            end
        end
        bus.keycode = 8'h00;
    endtask

    task automatic test_drop();
        do_reset();
        for (int f = 0; f <= 30; f++) begin
            bus.keycode = (f % 10 == 0) ? 8'h2c : 8'h00;
            step();
        end
        bus.keycode = 8'h00;
        chk("drop_active", int'(bus.missile_active), 7);
        chk("drop_y0", int'(bus.MissileY[9:0]), 314);
        chk("drop_y1", int'(bus.MissileY[19:10]), 354);
        chk("drop_y2", int'(bus.MissileY[29:20]), 394);
    endtask

    task automatic test_hit();
        int   k;
        logic saw;
        do_reset();
        set_alien(0, 10'd330, 10'd300);
        bus.keycode = 8'h2c;
        step();
        bus.keycode = 8'h00;
        k = 0;
        while (bus.missile_active[0] && k < 60) begin
            step();
            k++;
        end
        chk("hit_frame", k, 29);
        chk("hit_pulse", int'(bus.hit_pulse), 1);
        chk("hit_sticky", int'(bus.alien_hit), 1);
        chk("hit_park_y", int'(bus.MissileY[9:0]), 434);
        step();
        chk("hit_pulse_clr", int'(bus.hit_pulse), 0);
        chk("hit_sticky2", int'(bus.alien_hit), 1);
        bus.keycode = 8'h2c;
        step();
        bus.keycode = 8'h00;
        k = 0;
        saw = 1'b0;
        while (bus.missile_active[0] && k < 200) begin
            step();
            k++;
            if (bus.hit_pulse != 12'h000) saw = 1'b1;
        end
        chk("pass_dead_frame", k, 108);
        chk("pass_dead_pulse", int'(saw), 0);
    endtask

    task automatic test_contention();
        do_reset();
        for (int f = 0; f <= 30; f++) begin
            bus2.keycode = (f == 0 || f == 2) ? 8'h2c : 8'h00;
            step();
        end
        bus2.keycode = 8'h00;
        chk("ct_active_pre", int'(bus2.missile_active), 3);
        chk("ct_y0_pre", int'(bus2.MissileY[9:0]), 314);
        chk("ct_y1_pre", int'(bus2.MissileY[19:10]), 322);
        set_alien2(5, 10'd330, 10'd300);
        step();
        chk("ct_active", int'(bus2.missile_active), 2);
        chk("ct_y1_move", int'(bus2.MissileY[19:10]), 318);
        chk("ct_pulse", int'(bus2.hit_pulse), 32);
        chk("ct_hit", int'(bus2.alien_hit), 32);
        step();
        chk("ct_y1_pass", int'(bus2.MissileY[19:10]), 314);
        chk("ct_pulse_clr", int'(bus2.hit_pulse), 0);
    endtask

    task automatic test_all_dead();
        do_reset();
        for (int j = 0; j < 12; j++) set_alien(j, 10'd330, 10'd400);
        for (int n = 0; n < 12; n++) begin
            bus.keycode = 8'h2c;
            step();
            bus.keycode = 8'h00;
            for (int s = 0; s < 9; s++) step();
            chk($sformatf("ad_hits_%0d", n), int'(bus.alien_hit),
                (1 << (n + 1)) - 1);
        end
        chk("ad_all_dead", int'(bus.all_dead), 1);
        chk("ad_idle", int'(bus.missile_active), 0);
        bus.keycode = 8'h2c;
        step();
        bus.keycode = 8'h00;
        step();
        step();
        step();
        chk("clr_pre_y", int'(bus.MissileY[9:0]), 422);
        bus.clear_hits = 1'b1;
        step();
        bus.clear_hits = 1'b0;
        chk("clr_hits", int'(bus.alien_hit), 0);
        chk("clr_dead", int'(bus.all_dead), 0);
        chk("clr_pulse", int'(bus.hit_pulse), 0);
        chk("clr_moved", int'(bus.MissileY[9:0]), 418);
        chk("clr_active", int'(bus.missile_active), 1);
        step();
        chk("clr_rehit", int'(bus.hit_pulse), 1);
        chk("clr_retire", int'(bus.missile_active), 0);
    endtask

    task automatic test_midflight_reset();
        do_reset();
        bus.keycode = 8'h2c;
        step();
        bus.keycode = 8'h00;
        step();
        step();
        #2;
        Reset = 1'b1;
        #1;
        chk("mid_active", int'(bus.missile_active), 0);
        chk("mid_y", int'(bus.MissileY[9:0]), 434);
        chk("mid_x", int'(bus.MissileX[9:0]), 337);
        Reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_hold();
        test_cooldown();
        test_drop();
        test_hit();
        test_contention();
        test_all_dead();
        test_midflight_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
